id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand selection for the 5-stage MIPS pipeline.
- Sits directly upstream of the ALU and drives its ALUCode, A and B inputs.
- Registers decoded ID fields and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

---
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with EX-stage operand selection.
//               Forwards from EX/MEM and MEM/WB, detects load-use hazards,
//               inserts bubbles and honours downstream stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [4:0]        id_alucode_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [4:0]        id_shamt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_alusrc_i,
    input  logic              id_shift_imm_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_memwrite_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_regwrite_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic              ex_valid_o,
    output logic [4:0]        ex_alucode_o,
    output logic [DATA_W-1:0] ex_a_o,
    output logic [DATA_W-1:0] ex_b_o,
    output logic [DATA_W-1:0] ex_store_data_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_regwrite_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              load_use_o
);

    localparam logic [4:0] c_ALU_SLL = 5'b10000;
    localparam logic [4:0] c_ALU_SRL = 5'b10001;
    localparam logic [4:0] c_ALU_SRA = 5'b10010;

    // Everything the EX stage remembers about its instruction.
    typedef struct packed {
        logic              valid;
        logic [4:0]        alucode;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              alusrc;
        logic              shift_imm;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
    } ex_fields_t;

    ex_fields_t        ex_q;
    ex_fields_t        ex_d;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    logic [DATA_W-1:0] w_a_raw;
    logic [DATA_W-1:0] w_a;
    logic              w_is_shift;
    logic              w_load_use;

    // Operand forwarding: EX/MEM beats MEM/WB, register 0 never forwards.
    always_comb begin
        w_fwd_rs = ex_q.rs_data;
        w_fwd_rt = ex_q.rt_data;
        if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_q.rs))
            w_fwd_rs = memwb_result_i;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_q.rs))
            w_fwd_rs = exmem_result_i;
        if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_q.rt))
            w_fwd_rt = memwb_result_i;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_q.rt))
            w_fwd_rt = exmem_result_i;
    end

    // A load in EX whose destination the ID instruction reads must stall ID.
    // rt only counts when it is a real source: register operand or store data.
    assign w_load_use = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid_i
                     && ((ex_q.rd == id_rs_i)
                         || ((ex_q.rd == id_rt_i) && (!id_alusrc_i || id_memwrite_i)))
                     && !stall_i && !flush_i;

    // Next-state selection: flush, then stall, then load-use bubble, then load.
    always_comb begin
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (stall_i) begin
            // Capture forwarded values so a retiring source is not lost.
            ex_d.rs_data = w_fwd_rs;
            ex_d.rt_data = w_fwd_rt;
        end else if (w_load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = id_valid_i;
            ex_d.alucode   = id_alucode_i;
            ex_d.rs_data   = id_rs_data_i;
            ex_d.rt_data   = id_rt_data_i;
            ex_d.imm       = id_imm_i;
            ex_d.shamt     = id_shamt_i;
            ex_d.rs        = id_rs_i;
            ex_d.rt        = id_rt_i;
            ex_d.rd        = id_rd_i;
            ex_d.alusrc    = id_alusrc_i;
            ex_d.shift_imm = id_shift_imm_i;
            ex_d.regwrite  = id_regwrite_i & id_valid_i;
            ex_d.memread   = id_memread_i  & id_valid_i;
            ex_d.memwrite  = id_memwrite_i & id_valid_i;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    // Operand A: shamt for immediate shifts; shift amounts keep only 5 bits.
    always_comb begin
        w_is_shift = (ex_q.alucode == c_ALU_SLL) || (ex_q.alucode == c_ALU_SRL)
                  || (ex_q.alucode == c_ALU_SRA);
        w_a_raw    = ex_q.shift_imm ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : w_fwd_rs;
        w_a        = w_is_shift ? {{(DATA_W-5){1'b0}}, w_a_raw[4:0]} : w_a_raw;
    end

    assign ex_valid_o      = ex_q.valid;
    assign ex_alucode_o    = ex_q.alucode;
    assign ex_a_o          = w_a;
    assign ex_b_o          = ex_q.alusrc ? ex_q.imm : w_fwd_rt;
    assign ex_store_data_o = w_fwd_rt;
    assign ex_rd_o         = ex_q.rd;
    assign ex_regwrite_o   = ex_q.regwrite & ex_q.valid;
    assign ex_memread_o    = ex_q.memread  & ex_q.valid;
    assign ex_memwrite_o   = ex_q.memwrite & ex_q.valid;
    assign load_use_o      = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage with an
//               instruction-level reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam logic [4:0] c_ADD = 5'b00000;
    localparam logic [4:0] c_SLL = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i;
    logic        id_valid_i;
    logic [4:0]  id_alucode_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_shamt_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic        id_alusrc_i, id_shift_imm_i, id_regwrite_i, id_memread_i, id_memwrite_i;
    logic        exmem_regwrite_i;
    logic [4:0]  exmem_rd_i;
    logic [31:0] exmem_result_i;
    logic        memwb_regwrite_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_result_i;
    logic        ex_valid_o;
    logic [4:0]  ex_alucode_o;
    logic [31:0] ex_a_o, ex_b_o, ex_store_data_o;
    logic [4:0]  ex_rd_o;
    logic        ex_regwrite_o, ex_memread_o, ex_memwrite_o, load_use_o;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_alucode_i(id_alucode_i),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
        .id_shamt_i(id_shamt_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_alusrc_i(id_alusrc_i), .id_shift_imm_i(id_shift_imm_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .id_memwrite_i(id_memwrite_i),
        .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
        .exmem_result_i(exmem_result_i),
        .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i),
        .memwb_result_i(memwb_result_i),
        .ex_valid_o(ex_valid_o), .ex_alucode_o(ex_alucode_o), .ex_a_o(ex_a_o),
        .ex_b_o(ex_b_o), .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o),
        .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
        .ex_memwrite_o(ex_memwrite_o), .load_use_o(load_use_o)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction currently sitting in EX.
    typedef struct packed {
        logic        valid;
        logic [4:0]  alucode;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  shamt, rs, rt, rd;
        logic        alusrc, shimm, rw, mr, mw;
    } instr_t;

    instr_t m;

    function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] stored);
        if (exmem_regwrite_i && exmem_rd_i != 5'd0 && exmem_rd_i == idx) return exmem_result_i;
        if (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == idx) return memwb_result_i;
        return stored;
    endfunction

    function automatic logic m_lu();
        logic reads;
        reads = (m.rd == id_rs_i) || ((m.rd == id_rt_i) && (!id_alusrc_i || id_memwrite_i));
        return !stall_i && !flush_i && m.valid && m.mr && (m.rd != 5'd0) && id_valid_i && reads;
    endfunction

    function automatic logic [31:0] m_a();
        logic [31:0] a;
        a = m.shimm ? {27'd0, m.shamt} : m_fwd(m.rs, m.rsd);
        if (m.alucode inside {5'b10000, 5'b10001, 5'b10010}) a = a % 32;
        return a;
    endfunction

    // Model update on each edge, following the priority flush > stall > hazard > load.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
        end else if (flush_i) begin
            m <= '0;
        end else if (stall_i) begin
            m.rsd <= m_fwd(m.rs, m.rsd);
            m.rtd <= m_fwd(m.rt, m.rtd);
        end else if (m_lu()) begin
            m <= '0;
        end else begin
            m <= '{valid: id_valid_i, alucode: id_alucode_i, rsd: id_rs_data_i,
                   rtd: id_rt_data_i, imm: id_imm_i, shamt: id_shamt_i, rs: id_rs_i,
                   rt: id_rt_i, rd: id_rd_i, alusrc: id_alusrc_i, shimm: id_shift_imm_i,
                   rw: id_regwrite_i & id_valid_i, mr: id_memread_i & id_valid_i,
                   mw: id_memwrite_i & id_valid_i};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_valid",    {31'd0, ex_valid_o},    {31'd0, m.valid});
        chk("cmp_alucode",  {27'd0, ex_alucode_o},  {27'd0, m.alucode});
        chk("cmp_a",        ex_a_o,                 m_a());
        chk("cmp_b",        ex_b_o,                 m.alusrc ? m.imm : m_fwd(m.rt, m.rtd));
        chk("cmp_store",    ex_store_data_o,        m_fwd(m.rt, m.rtd));
        chk("cmp_rd",       {27'd0, ex_rd_o},       {27'd0, m.rd});
        chk("cmp_regwrite", {31'd0, ex_regwrite_o}, {31'd0, m.valid & m.rw});
        chk("cmp_memread",  {31'd0, ex_memread_o},  {31'd0, m.valid & m.mr});
        chk("cmp_memwrite", {31'd0, ex_memwrite_o}, {31'd0, m.valid & m.mw});
        chk("cmp_load_use", {31'd0, load_use_o},    {31'd0, m_lu()});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] alu, input logic [4:0] rs,
                          input logic [31:0] rsd, input logic [4:0] rt, input logic [31:0] rtd,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [4:0] sh,
                          input logic alusrc, input logic shimm, input logic rw,
                          input logic mr, input logic mw);
        id_valid_i = v;      id_alucode_i = alu;    id_rs_i = rs;
        id_rs_data_i = rsd;  id_rt_i = rt;          id_rt_data_i = rtd;
        id_rd_i = rd;        id_imm_i = imm;        id_shamt_i = sh;
        id_alusrc_i = alusrc; id_shift_imm_i = shimm;
        id_regwrite_i = rw;  id_memread_i = mr;     id_memwrite_i = mw;
    endtask

    task automatic set_fw(input logic exrw, input logic [4:0] exrd, input logic [31:0] exres,
                          input logic wbrw, input logic [4:0] wbrd, input logic [31:0] wbres);
        exmem_regwrite_i = exrw; exmem_rd_i = exrd; exmem_result_i = exres;
        memwb_regwrite_i = wbrw; memwb_rd_i = wbrd; memwb_result_i = wbres;
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        set_id(0, c_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fw(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Reset mid-stream, then first post-reset edge loads.
        set_id(1, c_ADD, 1, 32'h11, 2, 32'h22, 4, 0, 0, 0, 0, 1, 0, 0);
        rst_n = 1'b1;
        tick(); mid();
        chk("rst_pre_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("rst_pre_a", ex_a_o, 32'h11);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("rst_async_a", ex_a_o, 32'd0);
        chk("rst_async_b", ex_b_o, 32'd0);
        chk("rst_async_rw", {31'd0, ex_regwrite_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); mid();
        chk("rst_post_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("rst_post_b", ex_b_o, 32'h22);

        // Forwarding: EX/MEM, EX/MEM over MEM/WB, MEM/WB alone, register 0.
        set_id(1, c_ADD, 3, 32'h5, 0, 32'h7, 6, 0, 0, 0, 0, 1, 0, 0);
        set_fw(1, 3, 32'h10, 0, 0, 0);
        tick(); mid();
        chk("fwd_exmem", ex_a_o, 32'h10);
        set_fw(1, 3, 32'h10, 1, 3, 32'h20);
        #1;
        chk("fwd_exmem_prio", ex_a_o, 32'h10);
        set_fw(1, 5, 32'h10, 1, 3, 32'h20);
        #1;
        chk("fwd_memwb", ex_a_o, 32'h20);
        set_id(1, c_ADD, 0, 32'h9, 0, 32'hA, 6, 0, 0, 0, 0, 1, 0, 0);
        set_fw(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        tick(); mid();
        chk("fwd_r0_a", ex_a_o, 32'h9);
        chk("fwd_r0_b", ex_b_o, 32'hA);

        // Shifts and immediate operand.
        set_fw(0, 0, 0, 0, 0, 0);
        set_id(1, c_SLL, 0, 0, 5, 32'h1, 7, 0, 4, 0, 1, 1, 0, 0);
        tick(); mid();
        chk("sll_a", ex_a_o, 32'h4);
        chk("sll_b", ex_b_o, 32'h1);
        set_id(1, c_SLL, 8, 32'hFFFF_FF23, 9, 32'h2, 7, 0, 0, 0, 0, 1, 0, 0);
        tick(); mid();
        chk("sllv_a", ex_a_o, 32'h3);
        set_id(1, c_ADD, 1, 32'h1, 9, 32'h55, 7, 32'hFFFF_8000, 0, 1, 0, 1, 0, 0);
        tick(); mid();
        chk("imm_b", ex_b_o, 32'hFFFF_8000);
        chk("imm_store", ex_store_data_o, 32'h55);
        set_id(0, c_ADD, 1, 32'h1, 2, 32'h2, 7, 0, 0, 0, 0, 1, 1, 1);
        tick(); mid();
        chk("novalid_rw", {31'd0, ex_regwrite_o}, 32'd0);
        chk("novalid_mr", {31'd0, ex_memread_o}, 32'd0);

        // Load-use hazard with rs, then forwarding from MEM/WB.
        set_id(1, c_ADD, 1, 32'h100, 2, 0, 2, 32'h4, 0, 1, 0, 1, 1, 0);
        tick();
        set_id(1, c_ADD, 2, 32'h0, 3, 32'h3, 4, 0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("lu_rs", {31'd0, load_use_o}, 32'd1);
        tick();
        set_fw(1, 2, 32'h104, 0, 0, 0);
        mid();
        chk("lu_bubble_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("lu_bubble_rw", {31'd0, ex_regwrite_o}, 32'd0);
        tick();
        set_fw(0, 0, 0, 1, 2, 32'hCAFE);
        mid();
        chk("lu_after_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("lu_after_a", ex_a_o, 32'hCAFE);

        // Store data through rt triggers; immediate-form rt does not.
        set_fw(0, 0, 0, 0, 0, 0);
        set_id(1, c_ADD, 1, 32'h100, 2, 0, 2, 32'h4, 0, 1, 0, 1, 1, 0);
        tick();
        set_id(1, c_ADD, 1, 32'h200, 2, 0, 0, 32'h8, 0, 1, 0, 0, 0, 1);
        #1;
        chk("lu_store", {31'd0, load_use_o}, 32'd1);
        set_id(1, c_ADD, 1, 32'h200, 2, 0, 2, 32'h8, 0, 1, 0, 1, 0, 0);
        #1;
        chk("lu_addi_none", {31'd0, load_use_o}, 32'd0);
        set_id(1, c_ADD, 1, 32'h200, 2, 0, 0, 32'h8, 0, 1, 0, 0, 0, 1);
        tick(); mid();
        chk("lu_store_bubble", {31'd0, ex_valid_o}, 32'd0);

        // Stall while the MEM/WB source for rs retires.
        set_id(1, c_ADD, 5, 32'h1, 6, 32'h6, 7, 0, 0, 0, 0, 1, 0, 0);
        set_fw(0, 0, 0, 1, 5, 32'h77);
        tick();
        stall_i = 1'b1;
        set_id(1, c_ADD, 9, 32'h99, 9, 32'h99, 9, 0, 0, 0, 0, 1, 0, 0);
        mid();
        chk("stall_a0", ex_a_o, 32'h77);
        tick();
        set_fw(0, 0, 0, 0, 0, 0);
        mid();
        chk("stall_a1", ex_a_o, 32'h77);
        tick(); mid();
        chk("stall_a2", ex_a_o, 32'h77);
        tick();
        stall_i = 1'b0;
        mid();
        chk("stall_a3", ex_a_o, 32'h77);
        chk("stall_rd", {27'd0, ex_rd_o}, 32'd7);

        // Flush together with stall over a pending load-use.
        set_id(1, c_ADD, 1, 32'h100, 2, 0, 2, 32'h4, 0, 1, 0, 1, 1, 0);
        tick();
        set_id(1, c_ADD, 2, 32'h0, 3, 32'h3, 4, 0, 0, 0, 0, 1, 0, 0);
        stall_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("flush_lu", {31'd0, load_use_o}, 32'd0);
        tick();
        stall_i = 1'b0;
        flush_i = 1'b0;
        mid();
        chk("flush_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("flush_mr", {31'd0, ex_memread_o}, 32'd0);
        chk("flush_a", ex_a_o, 32'd0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
